// File: rtl/cnt_down_timer.sv
// Loadable down-counting timer with one-shot / auto-reload modes and a
// registered one-cycle terminal-count pulse on each expiry.
module cnt_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             pe,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;
    if (pe) begin
      cnt_d   = d;
      rld_d   = d;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (ce) begin
            // Reaching zero is not the expiry; the next ce at zero is.
            if (cnt_q == '0) begin
              tc_d = 1'b1;
              if (mode) cnt_d = rld_q;
              else      state_d = DONE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        DONE: if (start) begin
          cnt_d   = rld_q;
          state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = done_q;
  assign tc   = tc_q;

endmodule

// File: doc/cnt_down_timer.md
Name: cnt_down_timer

Overview:
- Loadable, programmable down-counting timer; the count-down counterpart of the team's loadable up-counter.
- Loads a terminal value and decrements on clock-enable. Flags expiry with a one-cycle terminal-count pulse.
- Either stops (one-shot) or reloads and repeats (auto-reload).
- Used as the tick/timeout generator beside the up-counters in the lab designs.

Parameters:
- WIDTH, 8, bit width of the counter, the reload register and d.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rstn  input  1  reset, synchronous, active-low.
- pe  input  1  parallel enable. Loads d into cnt and the reload register.
- ce  input  1  count enable; one decrement per cycle while running.
- d  input  WIDTH  load value.
- mode  input  1  0 = one-shot, 1 = auto-reload. Sampled at each expiry event.
- start  input  1  begins counting.
- stop  input  1  aborts counting; cnt is held.
- cnt  output  WIDTH  current count, registered.
- busy  output  1  1 while state = RUN.
- done  output  1  1 while state = DONE.
- tc  output  1  terminal-count pulse, registered, one cycle wide.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low (rstn). A low rstn at a rising edge forces cnt=0, rld=0, state=IDLE, tc=0. rstn changes between edges have no effect. Reset wins over every other input, including mid-RUN.
- States:
  - IDLE (busy=0, done=0)
  - RUN (busy=1, done=0)
  - DONE (busy=0, done=1)
- Priority at each edge: rstn > pe > stop > start > ce.
- pe=1, any state: cnt<=d, rld<=d, state<=IDLE, tc<=0.
- stop=1: RUN->IDLE with cnt held. Ignored in IDLE and DONE.
- start=1:
  - IDLE->RUN, cnt unchanged.
  - DONE->RUN with cnt<=rld.
  - Ignored in RUN.
- RUN, ce=1, cnt!=0: cnt<=cnt-1 (no wrap).
- RUN, ce=1, cnt==0 is the expiry event. On the next edge:
  - tc<=1 for exactly one cycle.
  - mode=1: cnt<=rld, stay in RUN.
  - mode=0: state<=DONE, cnt stays 0.
- Expiry period is rld+1 ce-qualified cycles. rld=0 in auto-reload expires on every ce cycle.
- RUN, ce=0: cnt and state hold.
- tc is 0 in every cycle not immediately following an expiry event. Back-to-back expiries (rld=0, ce held high) give tc held at 1.
- start with cnt==0 from IDLE is legal: the first ce is an expiry event.
- DONE holds cnt=0 until pe, start or reset.
- Arithmetic is unsigned WIDTH bits. The counter never decrements below 0 and never wraps to all-ones.
- Latency: every input takes effect at the first rising edge where it is sampled. Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
All scenarios use WIDTH=8.
1. Reset: in RUN with cnt=5, hold rstn=0 for one edge -> cnt=0, busy=0, done=0, tc=0. Pulse rstn low between edges only -> no change.
2. One-shot: pe with d=3, mode=0; start; ce=1 continuously -> cnt 3,2,1,0. The 4th ce edge is the expiry: tc=1 for one cycle, done=1, busy=0, cnt stays 0 for 10 further cycles.
3. Auto-reload: pe with d=2, mode=1; start; ce=1 -> cnt 2,1,0,2,1,0,2. tc pulses once per 3 ce cycles, busy stays 1. With d=0 -> tc=1 every cycle while ce=1.
4. ce gating: RUN, cnt=4, ce pattern 1,0,0,1,1,0,1 -> cnt 3,3,3,2,1,1,0. No tc until the next ce at cnt=0.
5. Priority:
   - In RUN, assert pe (d=7), stop, start and ce in the same cycle -> cnt=7, state IDLE, tc=0.
   - In RUN with cnt=5, assert stop and ce together -> IDLE, cnt=5.
6. Restart from DONE: after scenario 2, assert start -> cnt=3 (rld), busy=1, and the count repeats 3,2,1,0 with one tc pulse.
